// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter that serialises N_REQ requesters onto a single cache_controller port.
// One transaction is in flight at a time; each completes with a one-cycle tagged response.
module cache_req_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_wr,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_is_wr,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    cache_rd,
  output logic                    cache_wr,
  output logic [ADDR_W-1:0]       cache_addr,
  output logic [DATA_W-1:0]       cache_wdata,
  input  logic [DATA_W-1:0]       cache_rdata,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_is_wr_q, rsp_is_wr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              cache_rd_q, cache_rd_d;
  logic              cache_wr_q, cache_wr_d;
  logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
  logic [DATA_W-1:0] cache_wdata_q, cache_wdata_d;

  logic              found;
  logic [ID_W-1:0]   win;

  // Handshake: a request transfers on the rising edge where req_valid[i] and req_ready[i]
  // are both high; the requester holds valid and its fields stable until that edge.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
        found = 1'b1;
        win   = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
    req_ready = '0;
    if (!rst && state_q == IDLE && found) req_ready[win] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    lat_cnt_d     = lat_cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_is_wr_d   = rsp_is_wr_q;
    rsp_rdata_d   = rsp_rdata_q;
    cache_rd_d    = 1'b0;
    cache_wr_d    = 1'b0;
    cache_addr_d  = cache_addr_q;
    cache_wdata_d = cache_wdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          rr_ptr_d      = win;
          id_d          = win;
          cache_addr_d  = req_addr[int'(win)*ADDR_W +: ADDR_W];
          cache_wdata_d = req_wdata[int'(win)*DATA_W +: DATA_W];
          lat_cnt_d     = '0;
          if (req_wr[win]) begin
            cache_wr_d = 1'b1;
            state_d    = WR;
          end else begin
            cache_rd_d = 1'b1;
            state_d    = RD;
          end
        end
      end
      WR: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_is_wr_d = 1'b1;
        state_d     = RESP;
      end
      RD: begin
        // rdata is sampled on the last edge of the read window.
        if (lat_cnt_q == LAT_W'(RD_LAT - 1)) begin
          rsp_rdata_d = cache_rdata;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_is_wr_d = 1'b0;
          lat_cnt_d   = '0;
          state_d     = RESP;
        end else begin
          cache_rd_d = 1'b1;
          lat_cnt_d  = lat_cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= ID_W'(N_REQ - 1);
      id_q          <= '0;
      lat_cnt_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_is_wr_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      cache_rd_q    <= 1'b0;
      cache_wr_q    <= 1'b0;
      cache_addr_q  <= '0;
      cache_wdata_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      lat_cnt_q     <= lat_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_is_wr_q   <= rsp_is_wr_d;
      rsp_rdata_q   <= rsp_rdata_d;
      cache_rd_q    <= cache_rd_d;
      cache_wr_q    <= cache_wr_d;
      cache_addr_q  <= cache_addr_d;
      cache_wdata_q <= cache_wdata_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_is_wr   = rsp_is_wr_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign cache_rd    = cache_rd_q;
  assign cache_wr    = cache_wr_q;
  assign cache_addr  = cache_addr_q;
  assign cache_wdata = cache_wdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Randomised bench for cache_req_arbiter: simple cache memory, arbitration/memory reference
// model, and an expected-response queue checked by an independent monitor.
module tb_cache_req_arbiter;

  localparam int N      = 2;
  localparam int IDW    = 1;
  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            rsp_valid, rsp_is_wr;
  logic [IDW-1:0]  rsp_id;
  logic [DW-1:0]   rsp_rdata;
  logic            cache_rd, cache_wr;
  logic [AW-1:0]   cache_addr;
  logic [DW-1:0]   cache_wdata, cache_rdata;
  logic [1:0]      dbg_state;

  cache_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_is_wr(rsp_is_wr), .rsp_rdata(rsp_rdata),
    .cache_rd(cache_rd), .cache_wr(cache_wr), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- cache memory environment ----------------
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  logic [DW-1:0] cmem [0:65535];
  initial for (int a = 0; a < 65536; a++) cmem[a] = dflt(AW'(a));
  always @(posedge clk) if (cache_wr) cmem[cache_addr] <= cache_wdata;
  assign cache_rdata = cmem[cache_addr];

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [IDW-1:0] id;
    logic           wr;
    logic [DW-1:0]  rdata;
    logic [31:0]    acc_cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            last_grant = N - 1;
  logic [DW-1:0] last_rd    = '0;
  logic [AW-1:0] cur_addr   = '0;
  logic [DW-1:0] cur_wdata  = '0;
  int            rd_cnt = 0, wr_cnt = 0;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Next requester after the previous grant, wrapping, that is currently requesting.
  function automatic int pick_next();
    for (int k = 1; k <= N; k++)
      if (req_valid[(last_grant + k) % N]) return (last_grant + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_grant = N - 1;
    last_rd    = '0;
    rd_cnt     = 0;
    wr_cnt     = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != '0) begin
        int   w;
        exp_t e;
        w = pick_next();
        chk("grant", 64'(req_ready), (w < 0) ? 64'd0 : 64'(1) << w);
        if (w >= 0) begin
          e.id      = IDW'(w);
          e.wr      = req_wr[w];
          e.acc_cyc = 32'(cyc);
          cur_addr  = req_addr[w*AW +: AW];
          cur_wdata = req_wdata[w*DW +: DW];
          e.rdata   = e.wr ? '0 : ref_read(cur_addr);
          if (e.wr) ref_mem[cur_addr] = cur_wdata;
          exp_q.push_back(e);
          last_grant = w;
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
      if (cache_rd || cache_wr) begin
        chk("rd_wr_exclusive", 64'(cache_rd & cache_wr), 64'd0);
        chk("cache_addr", 64'(cache_addr), 64'(cur_addr));
        if (cache_wr) chk("cache_wdata", 64'(cache_wdata), 64'(cur_wdata));
        if (cache_rd) rd_cnt++;
        if (cache_wr) wr_cnt++;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_is_wr", 64'(rsp_is_wr), 64'(e.wr));
          chk("rsp_latency", 64'(cyc - int'(e.acc_cyc)), e.wr ? 64'd2 : 64'(RD_LAT + 1));
          if (e.wr) begin
            chk("rdata_hold", 64'(rsp_rdata), 64'(last_rd));
            chk("wr_cycles", 64'(wr_cnt), 64'd1);
          end else begin
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rd_cycles", 64'(rd_cnt), 64'(RD_LAT));
            last_rd = e.rdata;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called between edges; returns one step after the accepting rising edge.
  task automatic drive(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done = 0;
    req_valid[i]          = 1'b1;
    req_wr[i]             = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (req_ready[i]) done = 1;
    end
    if (!done) chk("accept_timeout", 64'(i), 64'hFFFF);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) chk("rsp_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, "_rsp_is_wr"}, 64'(rsp_is_wr), 64'd0);
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "_cache_rd"}, 64'(cache_rd), 64'd0);
    chk({tag, "_cache_wr"}, 64'(cache_wr), 64'd0);
    chk({tag, "_cache_addr"}, 64'(cache_addr), 64'd0);
    chk({tag, "_cache_wdata"}, 64'(cache_wdata), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // Asserts reset in the middle of a low phase; leaves rst high.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero(tag);
    model_reset();
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 16'h0004;
      1:       return 16'h0404;
      2:       return 16'hFFFF;
      default: return AW'($urandom_range(0, 65535));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    check_zero("por");
    @(posedge clk);
    #1 rst = 1'b0;

    // req0 write then read back
    drive(0, 1'b1, 16'h0004, 32'h1111AAAA);
    wait_idle();
    drive(0, 1'b0, 16'h0004, 32'h0);
    wait_idle();

    // req1 at the top address
    drive(1, 1'b1, 16'hFFFF, 32'hDEADBEEF);
    wait_idle();
    drive(1, 1'b0, 16'hFFFF, 32'h0);
    wait_idle();

    // both requesters valid while reset is held
    mid_reset("rst_mid");
    fork
      drive(0, 1'b0, 16'h0404, 32'h0);
      drive(1, 1'b0, 16'h0804, 32'h0);
      begin
        repeat (2) @(negedge clk);
        chk("ready_in_rst", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    wait_idle();

    // req0 stays busy; req1 raised once mid-stream
    fork
      begin
        drive(0, 1'b0, 16'h0004, 32'h0);
        drive(0, 1'b1, 16'h0100, 32'h01234567);
        drive(0, 1'b0, 16'h0100, 32'h0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 drive(1, 1'b0, 16'hFFFF, 32'h0);
      end
    join
    wait_idle();

    // reset one cycle into a read: no response may follow
    drive(0, 1'b0, 16'h0004, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_rd_cache_rd", 64'(cache_rd), 64'd0);
    chk("rst_rd_rsp_valid", 64'(rsp_valid), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    drive(0, 1'b0, 16'h0004, 32'h0);
    wait_idle();

    // randomised traffic
    for (int r = 0; r < 40; r++) begin
      int mask;
      mask = $urandom_range(1, 3);
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          automatic int j = i;
          automatic logic wr = 1'($urandom_range(0, 1));
          automatic logic [AW-1:0] a = pick_addr();
          automatic logic [DW-1:0] d = $urandom;
          fork
            drive(j, wr, a, d);
          join_none
        end
      end
      wait fork;
      wait_idle();
    end

    repeat (4) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
